// File: rtl/layer_readback.sv
// Streams Layer0/Layer1 result memories out over valid/ready with layer tag, last flag and checksum.
// Reads are only issued when the returning word is guaranteed a slot in the 2-entry output FIFO.
module layer_readback #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 13,
  parameter int L0_DEPTH = 4096,
  parameter int L1_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic              csel,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_layer,
  output logic              out_last,
  output logic [23:0]       checksum,
  output logic              done
);

  localparam logic [ADDR_W-1:0] L0_LAST = ADDR_W'(L0_DEPTH - 1);
  localparam logic [ADDR_W-1:0] L1_LAST = ADDR_W'(L1_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_L0,
    S_RD_L1,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                csel_q, csel_d;
  logic                two_layer_q, two_layer_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic                head_layer_q, head_layer_d;
  logic                head_last_q, head_last_d;
  logic [DATA_W-1:0]   tail_data_q, tail_data_d;
  logic                tail_layer_q, tail_layer_d;
  logic                tail_last_q, tail_last_d;
  logic                infl_q, infl_d;
  logic                infl_layer_q, infl_layer_d;
  logic                infl_last_q, infl_last_d;
  logic [23:0]         checksum_q, checksum_d;

  logic                pop, push, reading, issue, at_end, issue_last;
  logic [1:0]          occ;

  always_comb begin
    pop     = (cnt_q != 2'd0) && out_ready;
    push    = infl_q;
    // Words that will occupy the FIFO next cycle; a read now is safe only if that leaves a slot.
    occ     = cnt_q - {1'b0, pop} + {1'b0, infl_q};
    reading = (state_q == S_RD_L0) || (state_q == S_RD_L1);
    issue   = reading && (occ < 2'd2);
    at_end  = (state_q == S_RD_L0) ? (addr_q == L0_LAST) : (addr_q == L1_LAST);
    issue_last = issue && at_end && ((state_q == S_RD_L1) || !two_layer_q);

    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    addr_d       = addr_q;
    csel_d       = csel_q;
    two_layer_d  = two_layer_q;
    cnt_d        = cnt_q;
    head_data_d  = head_data_q;
    head_layer_d = head_layer_q;
    head_last_d  = head_last_q;
    tail_data_d  = tail_data_q;
    tail_layer_d = tail_layer_q;
    tail_last_d  = tail_last_q;
    infl_d       = issue;
    infl_layer_d = csel_q;
    infl_last_d  = issue_last;
    checksum_d   = checksum_q;

    unique case ({push, pop})
      2'b01: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd2) begin
          head_data_d  = tail_data_q;
          head_layer_d = tail_layer_q;
          head_last_d  = tail_last_q;
        end else begin
          head_last_d  = 1'b0;
        end
      end
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          head_data_d  = cdata_rd;
          head_layer_d = infl_layer_q;
          head_last_d  = infl_last_q;
        end else begin
          tail_data_d  = cdata_rd;
          tail_layer_d = infl_layer_q;
          tail_last_d  = infl_last_q;
        end
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_data_d  = cdata_rd;
          head_layer_d = infl_layer_q;
          head_last_d  = infl_last_q;
        end else begin
          head_data_d  = tail_data_q;
          head_layer_d = tail_layer_q;
          head_last_d  = tail_last_q;
          tail_data_d  = cdata_rd;
          tail_layer_d = infl_layer_q;
          tail_last_d  = infl_last_q;
        end
      end
      default: ;
    endcase

    if (pop) begin
      checksum_d = checksum_q + 24'(head_data_q);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          checksum_d  = '0;
          two_layer_d = mode[1];
          addr_d      = '0;
          csel_d      = (mode == 2'd1);
          state_d     = (mode == 2'd1) ? S_RD_L1 : S_RD_L0;
        end
      end
      S_RD_L0, S_RD_L1: begin
        if (issue) begin
          if (!at_end) begin
            addr_d = addr_q + 1'b1;
          end else if ((state_q == S_RD_L0) && two_layer_q) begin
            addr_d  = '0;
            csel_d  = 1'b1;
            state_d = S_RD_L1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((cnt_d == 2'd0) && !infl_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      csel_q       <= 1'b0;
      two_layer_q  <= 1'b0;
      cnt_q        <= '0;
      head_data_q  <= '0;
      head_layer_q <= 1'b0;
      head_last_q  <= 1'b0;
      tail_data_q  <= '0;
      tail_layer_q <= 1'b0;
      tail_last_q  <= 1'b0;
      infl_q       <= 1'b0;
      infl_layer_q <= 1'b0;
      infl_last_q  <= 1'b0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      addr_q       <= addr_d;
      csel_q       <= csel_d;
      two_layer_q  <= two_layer_d;
      cnt_q        <= cnt_d;
      head_data_q  <= head_data_d;
      head_layer_q <= head_layer_d;
      head_last_q  <= head_last_d;
      tail_data_q  <= tail_data_d;
      tail_layer_q <= tail_layer_d;
      tail_last_q  <= tail_last_d;
      infl_q       <= infl_d;
      infl_layer_q <= infl_layer_d;
      infl_last_q  <= infl_last_d;
      checksum_q   <= checksum_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign crd       = issue;
  assign caddr_rd  = addr_q;
  assign csel      = csel_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_layer = head_layer_q;
  assign out_last  = head_last_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_layer_readback.sv
// Bench for layer_readback: vector table of whole jobs checked against a queue-based stream model,
// plus hand-written stall and mid-job reset sequences.
module tb_layer_readback;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 13;
  localparam int L0_DEPTH = 4096;
  localparam int L1_DEPTH = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        mode;
  logic              busy, crd, csel;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_layer, out_last;
  logic [23:0]       checksum;
  logic              done;

  layer_readback #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .L0_DEPTH(L0_DEPTH), .L1_DEPTH(L1_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .crd(crd),
    .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_layer(out_layer), .out_last(out_last),
    .checksum(checksum), .done(done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem0 [L0_DEPTH];
  logic [DATA_W-1:0] mem1 [L1_DEPTH];

  // Synchronous memories: data valid exactly one cycle after crd, junk otherwise.
  always @(posedge clk)
    cdata_rd <= crd ? (csel ? mem1[caddr_rd[9:0]] : mem0[caddr_rd]) : DATA_W'($urandom);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [15:0] lfsr;

  typedef struct { logic [DATA_W-1:0] data; logic layer; logic last; } word_t;
  word_t exp_q[$];

  typedef struct {
    logic [1:0] mode; int fill; int rpat; bit pulse; int n; longint cks; int lat;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fill_mem(input int kind);
    for (int a = 0; a < L0_DEPTH; a++)
      mem0[a] = (kind == 0) ? DATA_W'(a) : (kind == 1) ? DATA_W'(1) : DATA_W'($urandom);
    for (int a = 0; a < L1_DEPTH; a++)
      mem1[a] = (kind == 0) ? DATA_W'(a + 7) : (kind == 1) ? DATA_W'(2) : DATA_W'($urandom);
  endtask

  // Expected stream: every selected layer in address order, last flag only on the final word.
  task automatic build_model(input logic [1:0] m, output longint sum);
    exp_q.delete();
    sum = 0;
    if (m != 2'd1)
      for (int a = 0; a < L0_DEPTH; a++) exp_q.push_back('{mem0[a], 1'b0, 1'b0});
    if (m != 2'd0)
      for (int a = 0; a < L1_DEPTH; a++) exp_q.push_back('{mem1[a], 1'b1, 1'b0});
    exp_q[exp_q.size() - 1].last = 1'b1;
    foreach (exp_q[i]) sum = (sum + longint'(exp_q[i].data)) % 64'd16777216;
  endtask

  task automatic next_ready(input int rpat, input int k, output logic r);
    case (rpat)
      1: begin
        lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        r = lfsr[0];
      end
      2: r = ($urandom_range(0, 3) != 0);
      3: r = (k > 100);
      default: r = 1'b1;
    endcase
  endtask

  task automatic run_job(input logic [1:0] m, input int rpat, input bit pulse, input int n_req,
                         input longint cks_req, input int lat_req, input int abort_at,
                         input string tag);
    longint sum;
    int t0, k, budget, xfers, crds, first_crd, last_crd, early_crd;
    int crd_before, xfer_before, room_bad, stall_bad, busy_bad, done_k;
    bit held_valid, aborted;
    logic r;
    logic [DATA_W+1:0] held, got, want;
    word_t w;

    build_model(m, sum);
    xfers = 0; crds = 0; first_crd = -1; last_crd = -1; early_crd = 0;
    crd_before = 0; xfer_before = 0; room_bad = 0; stall_bad = 0; busy_bad = 0;
    done_k = -1; held_valid = 0; aborted = 0; held = '0;
    budget = n_req * 6 + 400;

    @(negedge clk);
    start = 1'b1; mode = m; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    forever begin
      k = cyc - t0;
      next_ready(rpat, k, r);
      out_ready = r;
      if (pulse) begin
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom);
      end
      #1;
      if (busy !== 1'b1) busy_bad++;
      if (crd_before - xfer_before > 2) room_bad++;
      if (crd) begin
        crds++;
        if (first_crd < 0) first_crd = k;
        last_crd = k;
        if (k <= 100) early_crd++;
      end
      got = {out_data, out_layer, out_last};
      if (held_valid && (!out_valid || got !== held)) stall_bad++;
      held_valid = out_valid && !out_ready;
      held = got;
      if (rpat == 3 && k == 100)
        check({tag, " stalled_word0"}, out_valid === 1'b1 && exp_q.size() > 0 &&
              out_data === exp_q[0].data, longint'(out_data), longint'(mem0[0]));
      if (out_valid && out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check({tag, " extra_word"}, 1'b0, longint'(got), -1);
        end else begin
          w = exp_q.pop_front();
          want = {w.data, w.layer, w.last};
          check({tag, " word"}, got === want, longint'(got), longint'(want));
        end
      end
      crd_before  += int'(crd);
      xfer_before += int'(out_valid && out_ready);
      if (abort_at >= 0 && xfers == abort_at) begin
        #1 reset = 1'b0;
        #1;
        check({tag, " async_busy"}, busy === 1'b0, longint'(busy), 0);
        check({tag, " async_crd"}, crd === 1'b0, longint'(crd), 0);
        check({tag, " async_valid"}, out_valid === 1'b0, longint'(out_valid), 0);
        check({tag, " async_checksum"}, checksum === 24'd0, longint'(checksum), 0);
        @(negedge clk);
        check({tag, " reset_no_crd"}, crd === 1'b0, longint'(crd), 0);
        reset = 1'b1;
        aborted = 1;
        break;
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (k > budget) begin
        check({tag, " done_timeout"}, 1'b0, k, budget);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (aborted) return;

    if (lat_req >= 0) check({tag, " done_latency"}, done_k == lat_req, done_k, lat_req);
    check({tag, " word_count"}, xfers == n_req, xfers, n_req);
    check({tag, " crd_count"}, crds == n_req, crds, n_req);
    check({tag, " checksum_model"}, longint'(checksum) == sum, longint'(checksum), sum);
    if (cks_req >= 0)
      check({tag, " checksum_const"}, longint'(checksum) == cks_req, longint'(checksum), cks_req);
    if (rpat == 0) begin
      check({tag, " first_crd"}, first_crd == 1, first_crd, 1);
      check({tag, " crd_gapless"}, last_crd == n_req, last_crd, n_req);
    end
    if (rpat == 3) check({tag, " crd_while_stalled"}, early_crd <= 2, early_crd, 2);
    check({tag, " fifo_room"}, room_bad == 0, room_bad, 0);
    check({tag, " stall_stable"}, stall_bad == 0, stall_bad, 0);
    check({tag, " busy_window"}, busy_bad == 0, busy_bad, 0);
    @(negedge clk);
    #1;
    check({tag, " done_one_cycle"}, done === 1'b0 && busy === 1'b0,
          longint'({done, busy}), 0);
    check({tag, " checksum_hold"}, longint'(checksum) == sum, longint'(checksum), sum);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = '0; out_ready = 1'b1; lfsr = 16'hACE1;
    vecs[0] = '{mode: 2'd0, fill: 0, rpat: 0, pulse: 0, n: 4096, cks: 64'h7FF800, lat: 4099};
    vecs[1] = '{mode: 2'd2, fill: 1, rpat: 0, pulse: 0, n: 5120, cks: 6144, lat: 5123};
    vecs[2] = '{mode: 2'd1, fill: 2, rpat: 1, pulse: 0, n: 1024, cks: -1, lat: -1};
    vecs[3] = '{mode: 2'd1, fill: 1, rpat: 0, pulse: 0, n: 1024, cks: 2048, lat: 1027};
    vecs[4] = '{mode: 2'd3, fill: 1, rpat: 2, pulse: 1, n: 5120, cks: 6144, lat: -1};
    vecs[5] = '{mode: 2'd2, fill: 2, rpat: 2, pulse: 0, n: 5120, cks: -1, lat: -1};

    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {busy, crd, csel, out_valid, out_last, done} === 6'b0,
          longint'({busy, crd, csel, out_valid, out_last, done}), 0);
    check("reset_addr", caddr_rd === '0, longint'(caddr_rd), 0);
    check("reset_out", {out_data, out_layer} === '0, longint'({out_data, out_layer}), 0);
    check("reset_checksum", checksum === '0, longint'(checksum), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      fill_mem(vecs[i].fill);
      run_job(vecs[i].mode, vecs[i].rpat, vecs[i].pulse, vecs[i].n, vecs[i].cks,
              vecs[i].lat, -1, $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Downstream blocked for 100 cycles after start, then released.
    fill_mem(2);
    run_job(2'd0, 3, 1'b0, 4096, -1, -1, -1, "stall100");

    // Reset mid-L0, then a fresh Layer1-only job must complete cleanly.
    fill_mem(0);
    run_job(2'd0, 0, 1'b0, 4096, -1, -1, 1000, "abort");
    repeat (2) @(negedge clk);
    run_job(2'd1, 0, 1'b0, 1024, 64'd530944, 1027, -1, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
